// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - load/store encodings, bus size codes and FSM states for mem_access_ctrl
package mem_pkg;

    localparam logic [3:0] LD_NONE = 4'd0;
    localparam logic [3:0] LD_LB   = 4'd1;
    localparam logic [3:0] LD_LBU  = 4'd2;
    localparam logic [3:0] LD_LH   = 4'd3;
    localparam logic [3:0] LD_LHU  = 4'd4;
    localparam logic [3:0] LD_LW   = 4'd5;

    localparam logic [3:0] ST_NONE = 4'd0;
    localparam logic [3:0] ST_SB   = 4'd1;
    localparam logic [3:0] ST_SH   = 4'd2;
    localparam logic [3:0] ST_SW   = 4'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [1:0] access_size(input logic [3:0] lt, input logic [3:0] st);
        if (st == ST_SB || lt == LD_LB || lt == LD_LBU)
            return SZ_BYTE;
        else if (st == ST_SH || lt == LD_LH || lt == LD_LHU)
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

    function automatic logic misaligned(input logic [3:0] lt, input logic [3:0] st,
                                        input logic [1:0] a);
        logic [1:0] sz;
        sz = access_size(lt, st);
        if (sz == SZ_HALF)
            return a[0];
        else if (sz == SZ_WORD)
            return a != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - SRAM-like data bus between mem_access_ctrl and memory
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// rtl/mem_access_ctrl_load_align.sv - lane extract and sign/zero extend of read data
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [3:0]  load_type,
    output logic [31:0] value
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{a, 3'b000} +: 8];
        h = rdata[{a[1], 4'b0000} +: 16];
        case (load_type)
            LD_LB:   value = {{24{b[7]}}, b};
            LD_LBU:  value = {24'b0, b};
            LD_LH:   value = {{16{h[15]}}, h};
            LD_LHU:  value = {16'b0, h};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-bus master; MEM_ADDR_EXC_EN enables misalignment exceptions
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              exc_in,
    input  logic              flush,
    input  logic [3:0]        load_type,
    input  logic [3:0]        store_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    mem_access_ctrl_if.master bus,
    output logic              stall_req,
    output logic              load_valid,
    output logic [31:0]       load_result,
    output logic              adel,
    output logic              ades
);
    state_t      state, state_next;
    logic        killed, killed_next;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_ltype;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic        is_load, is_store, addr_err, start, req, capture;
    logic [31:0] aligned, wdata_rep;

    assign is_load  = load_type != LD_NONE;
    assign is_store = store_type != ST_NONE;

`ifdef MEM_ADDR_EXC_EN
    assign addr_err = misaligned(load_type, store_type, addr[1:0]);
    assign adel     = mem_valid & addr_err & is_load;
    assign ades     = mem_valid & addr_err & is_store;
`else
    assign addr_err = 1'b0;
    assign adel     = 1'b0;
    assign ades     = 1'b0;
`endif

    assign start = mem_valid & (is_load | is_store) & ~exc_in & ~flush & ~addr_err;

    always_comb begin
        case (store_type)
            ST_SB:   wdata_rep = {4{wdata[7:0]}};
            ST_SH:   wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // A flush coinciding with the response is treated like an earlier kill.
    always_comb begin
        state_next  = state;
        killed_next = killed;
        stall_req   = 1'b0;
        req         = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                stall_req = start;
                if (start)
                    state_next = S_REQ;
            end
            S_REQ: begin
                req       = 1'b1;
                stall_req = 1'b1;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        capture    = ~flush;
                        state_next = flush ? S_IDLE : S_DONE;
                    end else begin
                        state_next  = S_WAIT;
                        killed_next = flush;
                    end
                end else if (flush) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (bus.data_data_ok) begin
                    capture     = ~(killed | flush);
                    state_next  = (killed | flush) ? S_IDLE : S_DONE;
                    killed_next = 1'b0;
                end else if (flush) begin
                    killed_next = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            killed      <= 1'b0;
            lat_addr    <= 32'b0;
            lat_wdata   <= 32'b0;
            lat_ltype   <= LD_NONE;
            lat_wr      <= 1'b0;
            lat_size    <= 2'b0;
            load_result <= 32'b0;
        end else begin
            state  <= state_next;
            killed <= killed_next;
            if (state == S_IDLE && start) begin
                lat_addr  <= addr;
                lat_wdata <= wdata_rep;
                lat_ltype <= is_store ? LD_NONE : load_type;
                lat_wr    <= is_store;
                lat_size  <= access_size(load_type, store_type);
            end
            if (capture && lat_ltype != LD_NONE)
                load_result <= aligned;
        end
    end

    load_align u_load_align (
        .rdata     (bus.data_rdata),
        .a         (lat_addr[1:0]),
        .load_type (lat_ltype),
        .value     (aligned)
    );

    assign bus.data_req   = req;
    assign bus.data_wr    = lat_wr;
    assign bus.data_size  = lat_size;
    assign bus.data_addr  = lat_addr;
    assign bus.data_wdata = lat_wdata;
    assign load_valid     = (state == S_DONE) && (lat_ltype != LD_NONE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid = 1'b0, exc_in = 1'b0, flush = 1'b0;
    logic [3:0]  load_type = 4'd0, store_type = 4'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        stall_req, load_valid, adel, ades;
    logic [31:0] load_result;
    logic [31:0] sb[$];
    logic [31:0] exp_v;
    int          total = 0, bad = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .exc_in      (exc_in),
        .flush       (flush),
        .load_type   (load_type),
        .store_type  (store_type),
        .addr        (addr),
        .wdata       (wdata),
        .bus         (bus),
        .stall_req   (stall_req),
        .load_valid  (load_valid),
        .load_result (load_result),
        .adel        (adel),
        .ades        (ades)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && load_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_load_valid: got load_result=%h, required no load_valid", load_result);
            end else begin
                exp_v = sb.pop_front();
                if (load_result !== exp_v) begin
                    bad++;
                    $display("FAIL load_result: got %h, required %h", load_result, exp_v);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] lt, input logic [3:0] st,
                            input logic [31:0] a, input logic [31:0] wd);
        mem_valid  = 1'b1;
        load_type  = lt;
        store_type = st;
        addr       = a;
        wdata      = wd;
    endtask

    task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rd);
        bus.data_addr_ok = aok;
        bus.data_data_ok = dok;
        bus.data_rdata   = rd;
    endtask

    task automatic idle_in;
        mem_valid  = 1'b0;
        load_type  = LD_NONE;
        store_type = ST_NONE;
        flush      = 1'b0;
        exc_in     = 1'b0;
    endtask

    task automatic test_reset;
        drive_bus(1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        total++;
        if ({bus.data_req, bus.data_wr, bus.data_size} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got req/wr/size=%b, required 0000", {bus.data_req, bus.data_wr, bus.data_size});
        end
        total++;
        if ({bus.data_addr, bus.data_wdata} !== 64'b0) begin
            bad++; $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", bus.data_addr, bus.data_wdata);
        end
        total++;
        if ({stall_req, load_valid, adel, ades} !== 4'b0 || load_result !== 32'b0) begin
            bad++; $display("FAIL reset_out: got stall/lv/adel/ades=%b result=%h, required 0", {stall_req, load_valid, adel, ades}, load_result);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_lw_latency;
        tick(); drive_op(LD_LW, ST_NONE, 32'h8000_0010, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req} !== 2'b10) begin
            bad++; $display("FAIL lw_c0: got stall/req=%b, required 10", {stall_req, bus.data_req});
        end
        tick(); drive_bus(1'b1, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req, bus.data_wr, bus.data_size} !== 5'b11010 || bus.data_addr !== 32'h8000_0010) begin
            bad++; $display("FAIL lw_c1: got stall/req/wr/size=%b addr=%h, required 11010 80000010", {stall_req, bus.data_req, bus.data_wr, bus.data_size}, bus.data_addr);
        end
        tick(); drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF); sb.push_back(32'hDEAD_BEEF);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req} !== 2'b10) begin
            bad++; $display("FAIL lw_c2: got stall/req=%b, required 10", {stall_req, bus.data_req});
        end
        tick(); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req, load_valid} !== 3'b001) begin
            bad++; $display("FAIL lw_c3: got stall/req/lv=%b, required 001", {stall_req, bus.data_req, load_valid});
        end
        tick(); idle_in();
        @(negedge clk); total++;
        if (load_valid !== 1'b0 || load_result !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL lw_hold: got lv=%b result=%h, required 0 deadbeef", load_valid, load_result);
        end
    endtask

    task automatic do_load(input logic [3:0] lt, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] expv, input int delay);
        tick(); drive_op(lt, ST_NONE, a, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if (stall_req !== 1'b1) begin
            bad++; $display("FAIL ld_detect: got stall=%b, required 1", stall_req);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            @(negedge clk); total++;
            if ({stall_req, bus.data_req} !== 2'b11 || bus.data_addr !== a) begin
                bad++; $display("FAIL ld_hold: got stall/req=%b addr=%h, required 11 %h", {stall_req, bus.data_req}, bus.data_addr, a);
            end
        end
        tick(); drive_bus(1'b1, 1'b1, rd); sb.push_back(expv);
        @(negedge clk); total++;
        if (bus.data_req !== 1'b1 || bus.data_addr !== a) begin
            bad++; $display("FAIL ld_req: got req=%b addr=%h, required 1 %h", bus.data_req, bus.data_addr, a);
        end
        tick(); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({load_valid, stall_req} !== 2'b10) begin
            bad++; $display("FAIL ld_done: got lv/stall=%b, required 10", {load_valid, stall_req});
        end
        tick(); idle_in();
        @(negedge clk);
    endtask

    task automatic test_load_extend;
        logic [3:0]  lt_t[6] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LB, LD_LW};
        logic [31:0] a_t[6]  = '{32'h0000_0003, 32'h0000_0003, 32'h0000_0102, 32'h0000_0200, 32'h0000_0301, 32'h0000_0404};
        logic [31:0] rd_t[6] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h1234_F0F0, 32'h8011_2233, 32'hCAFE_F00D};
        logic [31:0] ex_t[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_F0F0, 32'h0000_0022, 32'hCAFE_F00D};
        for (int i = 0; i < 6; i++)
            do_load(lt_t[i], a_t[i], rd_t[i], ex_t[i], 0);
    endtask

    task automatic test_addr_ok_delay;
        do_load(LD_LW, 32'h8000_0020, 32'h0BAD_F00D, 32'h0BAD_F00D, 3);
    endtask

    task automatic test_store;
        logic [3:0]  st_t[3] = '{ST_SH, ST_SB, ST_SW};
        logic [31:0] a_t[3]  = '{32'h0000_1002, 32'h0000_1003, 32'h0000_0008};
        logic [31:0] wd_t[3] = '{32'h1234_ABCD, 32'h0000_00A5, 32'h1357_9BDF};
        logic [31:0] ew_t[3] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'h1357_9BDF};
        logic [1:0]  sz_t[3] = '{SZ_HALF, SZ_BYTE, SZ_WORD};
        for (int i = 0; i < 3; i++) begin
            tick(); drive_op(LD_NONE, st_t[i], a_t[i], wd_t[i]); drive_bus(1'b0, 1'b0, 32'd0);
            @(negedge clk); total++;
            if (stall_req !== 1'b1) begin
                bad++; $display("FAIL st_detect: got stall=%b, required 1", stall_req);
            end
            tick(); drive_bus(1'b1, 1'b1, 32'hFFFF_FFFF);
            @(negedge clk); total++;
            if ({bus.data_req, bus.data_wr, bus.data_size} !== {2'b11, sz_t[i]} ||
                bus.data_wdata !== ew_t[i] || bus.data_addr !== a_t[i]) begin
                bad++; $display("FAIL st_req: got req/wr/size=%b wdata=%h addr=%h, required %b %h %h",
                    {bus.data_req, bus.data_wr, bus.data_size}, bus.data_wdata, bus.data_addr, {2'b11, sz_t[i]}, ew_t[i], a_t[i]);
            end
            tick(); drive_bus(1'b0, 1'b0, 32'd0);
            @(negedge clk); total++;
            if ({load_valid, stall_req} !== 2'b00) begin
                bad++; $display("FAIL st_done: got lv/stall=%b, required 00", {load_valid, stall_req});
            end
            tick(); idle_in();
        end
    endtask

    task automatic test_flush_wait;
        tick(); drive_op(LD_LW, ST_NONE, 32'h0000_0100, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        tick(); drive_bus(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        tick(); drive_bus(1'b0, 1'b0, 32'd0); flush = 1'b1; mem_valid = 1'b0;
        @(negedge clk); total++;
        if (stall_req !== 1'b1) begin
            bad++; $display("FAIL fw_flush: got stall=%b, required 1", stall_req);
        end
        tick(); flush = 1'b0; drive_op(LD_LW, ST_NONE, 32'h0000_0200, 32'd0);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req} !== 2'b10) begin
            bad++; $display("FAIL fw_killed: got stall/req=%b, required 10", {stall_req, bus.data_req});
        end
        tick(); drive_bus(1'b0, 1'b1, 32'h1111_1111);
        @(negedge clk); total++;
        if (stall_req !== 1'b1) begin
            bad++; $display("FAIL fw_drain: got stall=%b, required 1", stall_req);
        end
        tick(); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({stall_req, bus.data_req, load_valid} !== 3'b100) begin
            bad++; $display("FAIL fw_restart: got stall/req/lv=%b, required 100", {stall_req, bus.data_req, load_valid});
        end
        tick(); drive_bus(1'b1, 1'b1, 32'h2222_2222); sb.push_back(32'h2222_2222);
        @(negedge clk); total++;
        if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0200) begin
            bad++; $display("FAIL fw_next_req: got req=%b addr=%h, required 1 00000200", bus.data_req, bus.data_addr);
        end
        tick(); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if (load_valid !== 1'b1) begin
            bad++; $display("FAIL fw_next_done: got lv=%b, required 1", load_valid);
        end
        tick(); idle_in();
        @(negedge clk);
    endtask

    task automatic test_flush_req;
        tick(); drive_op(LD_LW, ST_NONE, 32'h0000_0300, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        tick(); flush = 1'b1; mem_valid = 1'b0;
        @(negedge clk); total++;
        if (bus.data_req !== 1'b1) begin
            bad++; $display("FAIL fr_req: got req=%b, required 1", bus.data_req);
        end
        tick(); idle_in();
        @(negedge clk); total++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            bad++; $display("FAIL fr_withdrawn: got req/stall=%b, required 00", {bus.data_req, stall_req});
        end
    endtask

    task automatic test_exc;
        tick(); drive_op(LD_LW, ST_NONE, 32'h0000_0040, 32'd0); exc_in = 1'b1;
        @(negedge clk); total++;
        if (stall_req !== 1'b0) begin
            bad++; $display("FAIL exc_stall: got stall=%b, required 0", stall_req);
        end
        tick();
        @(negedge clk); total++;
        if (bus.data_req !== 1'b0) begin
            bad++; $display("FAIL exc_req: got req=%b, required 0", bus.data_req);
        end
        tick(); idle_in();
    endtask

    task automatic test_misaligned;
`ifdef MEM_ADDR_EXC_EN
        tick(); drive_op(LD_LW, ST_NONE, 32'h0000_1002, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({adel, ades, stall_req} !== 3'b100) begin
            bad++; $display("FAIL mis_lw: got adel/ades/stall=%b, required 100", {adel, ades, stall_req});
        end
        tick();
        @(negedge clk); total++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            bad++; $display("FAIL mis_noreq: got req/stall=%b, required 00", {bus.data_req, stall_req});
        end
        tick(); drive_op(LD_NONE, ST_SW, 32'h0000_1001, 32'd5);
        @(negedge clk); total++;
        if ({adel, ades, stall_req} !== 3'b010) begin
            bad++; $display("FAIL mis_sw: got adel/ades/stall=%b, required 010", {adel, ades, stall_req});
        end
        tick(); idle_in();
`else
        tick(); drive_op(LD_LW, ST_NONE, 32'h0000_1002, 32'd0); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if ({adel, ades, stall_req} !== 3'b001) begin
            bad++; $display("FAIL mis_lw: got adel/ades/stall=%b, required 001", {adel, ades, stall_req});
        end
        tick(); drive_bus(1'b1, 1'b1, 32'h4433_2211); sb.push_back(32'h4433_2211);
        @(negedge clk); total++;
        if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_1002) begin
            bad++; $display("FAIL mis_req: got req=%b addr=%h, required 1 00001002", bus.data_req, bus.data_addr);
        end
        tick(); drive_bus(1'b0, 1'b0, 32'd0);
        @(negedge clk); total++;
        if (load_valid !== 1'b1) begin
            bad++; $display("FAIL mis_done: got lv=%b, required 1", load_valid);
        end
        tick(); idle_in();
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw_latency();
        test_load_extend();
        test_addr_ok_delay();
        test_store();
        test_flush_wait();
        test_flush_req();
        test_exc();
        test_misaligned();
        tick(); tick();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
